// File: rtl/frame_scheduler_pkg.sv
// Shared types and defaults for the frame scheduler.
//   SchedState_t    : scheduler FSM states
//   DECIM_DEFAULT   : default DFT sample reads per analysis frame
//   TIMEOUT_DEFAULT : default per-stage cycle budget
//   satInc8         : 8-bit increment that sticks at 255
package CCHW;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    NF_RUN   = 2'd1,
    VIZ_RUN  = 2'd2,
    LED_WAIT = 2'd3
  } SchedState_t;

  localparam int DECIM_DEFAULT   = 4;
  localparam int TIMEOUT_DEFAULT = 65535;

  function automatic logic [7:0] satInc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/frame_scheduler_stage_timer.sv
// Per-stage watchdog counter for the frame scheduler.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   clear    : zero the count (wins over enable)
//   enable   : advance the count by one this cycle
//   terminal : high in the enabled cycle whose increment reaches TIMEOUT
module stage_timer #(
  parameter int TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  logic [15:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  // Flagged one cycle early so the owner leaves the stage on the very edge
  // at which the count would have reached TIMEOUT. Deliberately independent
  // of clear, because the owner folds terminal back into clear.
  assign terminal = enable && (count == LAST);

endmodule

// File: rtl/frame_scheduler.sv
// Frame scheduler: chains DFT -> NoteFinder -> LinearVisualizer -> LED driver
// with handshakes instead of a fixed delay line.
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   sampleRead  : DFT audio-buffer read pulse; every DECIM-th one is a trigger
//   nfStart     : starts NoteFinder        / nfFinished : NoteFinder done
//   vizStart    : starts LinearVisualizer  / vizValid   : visualizer output valid
//   ledStart    : starts LED driver frame  / ledDone    : LED driver frame done
//   busy        : scheduler not in IDLE
//   frameCount  : ledStart pulses issued (wraps)
//   dropCount   : triggers discarded while busy (saturates at 255)
//   timeoutErr  : sticky, some stage exceeded TIMEOUT cycles
module frame_scheduler
  import CCHW::*;
#(
  parameter int DECIM   = CCHW::DECIM_DEFAULT,
  parameter int TIMEOUT = CCHW::TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sampleRead,
  output logic        nfStart,
  input  logic        nfFinished,
  output logic        vizStart,
  input  logic        vizValid,
  output logic        ledStart,
  input  logic        ledDone,
  output logic        busy,
  output logic [15:0] frameCount,
  output logic [7:0]  dropCount,
  output logic        timeoutErr
);

  localparam logic [7:0] SC_LAST = 8'(DECIM - 1);

  SchedState_t state;
  logic [7:0]  sc;
  logic        ledBusy;
  logic        trigger;
  logic        ledFree;
  logic        stageDone;
  logic        timerClear;
  logic        timerEnable;
  logic        timerTc;

  assign trigger = sampleRead && (sc == SC_LAST);
  assign busy    = (state != IDLE);

  // A ledDone arriving together with vizValid frees the driver in time for
  // this frame; otherwise LED_WAIT would wait for a ledDone already consumed.
  assign ledFree = !ledBusy || ledDone;

  // Decimation counter runs regardless of FSM state so frame cadence stays
  // locked to the DFT even while triggers are being dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc <= '0;
    end else if (sampleRead) begin
      sc <= trigger ? 8'd0 : sc + 8'd1;
    end
  end

  // Any way out of a running stage is a state entry, so the timer restarts.
  always_comb begin
    stageDone = 1'b0;
    case (state)
      NF_RUN:   stageDone = nfFinished;
      VIZ_RUN:  stageDone = vizValid;
      LED_WAIT: stageDone = ledDone;
      default:  stageDone = 1'b0;
    endcase
    timerEnable = (state != IDLE);
    timerClear  = (state == IDLE) || stageDone || timerTc;
  end

  stage_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_stage_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timerClear),
    .enable  (timerEnable),
    .terminal(timerTc)
  );

  // Scheduler FSM. A stage completion in the same cycle as its timeout is
  // treated as success. ledBusy assignments later in the block override the
  // generic ledDone clear, giving set priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ledBusy    <= 1'b0;
      nfStart    <= 1'b0;
      vizStart   <= 1'b0;
      ledStart   <= 1'b0;
      frameCount <= '0;
      dropCount  <= '0;
      timeoutErr <= 1'b0;
    end else begin
      nfStart  <= 1'b0;
      vizStart <= 1'b0;
      ledStart <= 1'b0;

      if (ledDone) begin
        ledBusy <= 1'b0;
      end

      if (trigger && (state != IDLE)) begin
        dropCount <= satInc8(dropCount);
      end

      case (state)
        IDLE: begin
          if (trigger) begin
            nfStart <= 1'b1;
            state   <= NF_RUN;
          end
        end
        NF_RUN: begin
          if (nfFinished) begin
            vizStart <= 1'b1;
            state    <= VIZ_RUN;
          end else if (timerTc) begin
            timeoutErr <= 1'b1;
            state      <= IDLE;
          end
        end
        VIZ_RUN: begin
          if (vizValid) begin
            if (ledFree) begin
              ledStart   <= 1'b1;
              ledBusy    <= 1'b1;
              frameCount <= frameCount + 16'd1;
              state      <= IDLE;
            end else begin
              state <= LED_WAIT;
            end
          end else if (timerTc) begin
            timeoutErr <= 1'b1;
            state      <= IDLE;
          end
        end
        LED_WAIT: begin
          if (ledDone) begin
            ledStart   <= 1'b1;
            ledBusy    <= 1'b1;
            frameCount <= frameCount + 16'd1;
            state      <= IDLE;
          end else if (timerTc) begin
            timeoutErr <= 1'b1;
            ledBusy    <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 SHALL have parameter DECIM, default 4: DFT sample reads per analysis frame, legal range 1..255.
REQ-002 SHALL have parameter TIMEOUT, default 65535: max cycles to wait for any stage, legal range 1..65535.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-005 SHALL have port sampleRead, input, 1: one-cycle pulse per DFT audio-buffer read.
REQ-006 SHALL have port nfStart, output, 1: one-cycle pulse that starts a NoteFinder cycle.
REQ-007 SHALL have port nfFinished, input, 1: one-cycle pulse when NoteFinder completes.
REQ-008 SHALL have port vizStart, output, 1: one-cycle pulse that starts LinearVisualizer.
REQ-009 SHALL have port vizValid, input, 1: one-cycle pulse when visualizer RGB/LEDCounts are valid.
REQ-010 SHALL have port ledStart, output, 1: one-cycle pulse that starts the LED driver frame.
REQ-011 SHALL have port ledDone, input, 1: one-cycle pulse when the LED driver finishes a frame.
REQ-012 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-013 SHALL have port frameCount, output, 16: count of ledStart pulses, wraps.
REQ-014 SHALL have port dropCount, output, 8: count of discarded triggers, saturating.
REQ-015 SHALL have port timeoutErr, output, 1: sticky flag, set on any stage timeout.

Function
REQ-016 SHALL count sampleRead pulses in an 8-bit counter sc; a pulse with sc==DECIM-1 is a trigger and sets sc to 0, any other pulse increments sc. The counter runs in every state.
REQ-017 SHALL implement FSM states IDLE, NF_RUN, VIZ_RUN, LED_WAIT.
REQ-018 SHALL, on a trigger in IDLE at cycle t, pulse nfStart at t+1 and enter NF_RUN.
REQ-019 SHALL discard a trigger that occurs outside IDLE and increment dropCount, saturating at 255.
REQ-020 SHALL, in NF_RUN, on nfFinished at cycle t, pulse vizStart at t+1 and enter VIZ_RUN.
REQ-021 SHALL, in VIZ_RUN, on vizValid at cycle t with ledBusy low, pulse ledStart at t+1, set ledBusy, increment frameCount, and return to IDLE.
REQ-022 SHALL, in VIZ_RUN, on vizValid with ledBusy high, enter LED_WAIT.
REQ-023 SHALL, in LED_WAIT, on ledDone at cycle t, pulse ledStart at t+1, keep ledBusy set, increment frameCount, and return to IDLE.
REQ-024 SHALL keep an internal ledBusy flag: set on ledStart, cleared on ledDone; if both occur in the same cycle, set wins.
REQ-025 SHALL ignore nfFinished and vizValid pulses that arrive in a state not waiting for them.
REQ-026 SHALL keep a 16-bit stage timer that clears on every state entry and increments each cycle in NF_RUN, VIZ_RUN and LED_WAIT.
REQ-027 SHALL, when the stage timer reaches TIMEOUT, set timeoutErr, return to IDLE, and clear ledBusy if the timeout occurred in LED_WAIT; no start pulse is issued for that frame.
REQ-028 SHALL drive all output pulses from registers, never more than one cycle wide, with at most one of nfStart, vizStart, ledStart high per cycle.

Reset
REQ-029 SHALL, on rst, asynchronously force state=IDLE, sc=0, stage timer=0, ledBusy=0, nfStart=vizStart=ledStart=0, busy=0, frameCount=0, dropCount=0, timeoutErr=0.
REQ-030 SHALL, on rst mid-frame, abandon the frame with no further start pulses; timeoutErr clears only on rst.

Structure
REQ-031 SHALL place the FSM state enum type (SchedState_t) and the default DECIM/TIMEOUT constants in package CCHW.
REQ-032 SHALL contain one sub-module, stage_timer: a 16-bit clear/enable counter with a terminal-count output.
REQ-033 SHALL be instantiated between DFT, NoteFinder, LinearVisualizer and LEDDriver2 in place of the fixed 4-cycle delay line.

Verification
REQ-034 SHALL verify the trigger path: DECIM=4, 4 sampleRead pulses with the last at cycle 100 -> nfStart at cycle 101 only, sc=0.
REQ-035 SHALL verify the full frame: nfFinished at 200 -> vizStart at 201; vizValid at 300 with ledBusy=0 -> ledStart at 301, frameCount=1, busy=0 at 302.
REQ-036 SHALL verify backpressure: a second frame's vizValid arrives while ledBusy=1 -> LED_WAIT; ledDone at 500 -> ledStart at 501, frameCount=2.
REQ-037 SHALL verify drops: 3 triggers arrive while in NF_RUN -> dropCount=3; 300 triggers arrive while busy -> dropCount=255.
REQ-038 SHALL verify timeout: TIMEOUT=10 and nfFinished never arrives -> timeoutErr=1 and IDLE 10 cycles after nfStart, with no vizStart.
REQ-039 SHALL verify async reset: rst asserted mid-cycle while in VIZ_RUN -> all outputs 0 before the next clk edge; no ledStart after rst deasserts.
